// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, IR/PC, register file
// and memory port across instruction phases, with memory stalls and illegal-opcode trap.
module multicycle_control #(
   parameter int USE_MEM_READY = 1,
   parameter int ILLEGAL_HALT  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_cond,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_LUI      = 4'd8,
      S_ALUWB    = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   state_t cur, nxt;
   logic   is_store;
   logic   ready;
   logic   pc_update;
   logic   branch;

   assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

   // opcode is only looked at in DECODE, so the load/store choice is captured there
   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= S_FETCH;
         is_store <= 1'b0;
      end else begin
         cur <= nxt;
         if (cur == S_DECODE) is_store <= opcode[5];
      end
   end

   always_comb begin
      nxt        = S_FETCH;
      mem_req    = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_update  = 1'b0;
      branch     = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      case (cur)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = ready;
            pc_update  = ready;
            nxt        = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               7'b0000011, 7'b0100011: nxt = S_MEMADR;
               7'b0110011:             nxt = S_EXECR;
               7'b0010011:             nxt = S_EXECI;
               7'b1100011:             nxt = S_BRANCH;
               7'b1101111:             nxt = S_JAL;
               7'b0110111:             nxt = S_LUI;
               default:                nxt = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            nxt       = is_store ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            nxt     = ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            nxt       = ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            nxt       = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b11;
            nxt       = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            nxt       = S_ALUWB;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
            nxt       = S_ALUWB;
         end
         S_ILLEGAL: nxt = (ILLEGAL_HALT != 0) ? S_ILLEGAL : S_FETCH;
         default:   nxt = S_FETCH;
      endcase
      // reset overrides everything so an abandoned access never strobes memory
      if (rst) begin
         mem_req    = 1'b0;
         adr_src    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_update  = 1'b0;
         branch     = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         result_src = 2'b00;
      end
   end

   assign pc_write = pc_update | (branch & branch_cond);
   assign illegal  = (cur == S_ILLEGAL);
   assign state    = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle table plus a halt/no-halt
// illegal-opcode sequence on a second instance.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst, branch_cond, mem_ready;
   logic [6:0] opcode;
   logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [3:0] state;
   logic       mem_req2, adr_src2, mem_write2, ir_write2, pc_write2, reg_write2, illegal2;
   logic [1:0] alu_src_a2, alu_src_b2, alu_op2, result_src2;
   logic [3:0] state2;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
      .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .illegal(illegal), .state(state));

   multicycle_control #(.USE_MEM_READY(1), .ILLEGAL_HALT(0)) dut_nh (
      .clk(clk), .rst(rst), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
      .mem_req(mem_req2), .adr_src(adr_src2), .mem_write(mem_write2), .ir_write(ir_write2),
      .pc_write(pc_write2), .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
      .alu_op(alu_op2), .result_src(result_src2), .illegal(illegal2), .state(state2));

   // {state, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, a, b, op, result_src, illegal}
   wire [18:0] act  = {state, mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                       alu_src_a, alu_src_b, alu_op, result_src, illegal};
   wire [18:0] act2 = {state2, mem_req2, adr_src2, mem_write2, ir_write2, pc_write2, reg_write2,
                       alu_src_a2, alu_src_b2, alu_op2, result_src2, illegal2};

   localparam logic [18:0] F_GO  = {4'd0,  6'b100110, 8'b00_10_00_10, 1'b0};
   localparam logic [18:0] F_WT  = {4'd0,  6'b100000, 8'b00_10_00_10, 1'b0};
   localparam logic [18:0] DEC   = {4'd1,  6'b000000, 8'b01_01_00_00, 1'b0};
   localparam logic [18:0] MAD   = {4'd2,  6'b000000, 8'b10_01_00_00, 1'b0};
   localparam logic [18:0] MRD   = {4'd3,  6'b110000, 8'b00_00_00_00, 1'b0};
   localparam logic [18:0] MWB   = {4'd4,  6'b000001, 8'b00_00_00_01, 1'b0};
   localparam logic [18:0] MWR   = {4'd5,  6'b111000, 8'b00_00_00_00, 1'b0};
   localparam logic [18:0] EXR   = {4'd6,  6'b000000, 8'b10_00_10_00, 1'b0};
   localparam logic [18:0] EXI   = {4'd7,  6'b000000, 8'b10_01_11_00, 1'b0};
   localparam logic [18:0] LUI   = {4'd8,  6'b000000, 8'b11_01_00_00, 1'b0};
   localparam logic [18:0] AWB   = {4'd9,  6'b000001, 8'b00_00_00_00, 1'b0};
   localparam logic [18:0] BR_T  = {4'd10, 6'b000010, 8'b10_00_01_00, 1'b0};
   localparam logic [18:0] BR_N  = {4'd10, 6'b000000, 8'b10_00_01_00, 1'b0};
   localparam logic [18:0] JAL   = {4'd11, 6'b000010, 8'b01_10_00_00, 1'b0};
   localparam logic [18:0] ILL   = {4'd12, 6'b000000, 8'b00_00_00_00, 1'b1};
   localparam logic [18:0] R_FET = {4'd0,  15'b0};
   localparam logic [18:0] R_MRD = {4'd3,  15'b0};

   localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                          OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111,
                          OP_I = 7'b0010011, OP_BAD = 7'b1111111;

   typedef struct {
      logic       rst;
      logic [6:0] opc;
      logic       bc;
      logic       rdy;
      logic [18:0] exp;
      string      name;
   } vec_t;

   vec_t vq[$];
   int   pass_cnt = 0;
   int   tot_cnt  = 0;

   task automatic add(input logic r, input logic [6:0] o, input logic b, input logic y,
                      input logic [18:0] e, input string n);
      vec_t v;
      v.rst = r; v.opc = o; v.bc = b; v.rdy = y; v.exp = e; v.name = n;
      vq.push_back(v);
   endtask

   task automatic check(input string n, input logic [18:0] a, input logic [18:0] e);
      tot_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %05h expected %05h", n, a, e);
   endtask

   task automatic drive(input logic r, input logic [6:0] o, input logic b, input logic y);
      @(negedge clk);
      rst = r; opcode = o; branch_cond = b; mem_ready = y;
      #1;
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; branch_cond = 1'b0; mem_ready = 1'b1;
      @(posedge clk);

      add(1, 7'd0, 0, 1, R_FET, "reset");
      add(0, OP_R, 0, 1, F_GO, "first_fetch");
      add(0, OP_R, 0, 1, DEC,  "r_dec");
      add(0, OP_R, 0, 1, EXR,  "r_exec");
      add(0, OP_R, 0, 1, AWB,  "r_wb");
      add(0, OP_LW, 0, 1, F_GO, "lw_fetch");
      add(0, OP_LW, 0, 1, DEC,  "lw_dec");
      add(0, OP_LW, 0, 1, MAD,  "lw_adr");
      add(0, OP_LW, 0, 0, MRD,  "lw_rd_wait1");
      add(0, OP_LW, 0, 0, MRD,  "lw_rd_wait2");
      add(0, OP_LW, 0, 1, MRD,  "lw_rd_done");
      add(0, OP_LW, 0, 1, MWB,  "lw_wb");
      add(0, OP_BR, 1, 0, F_WT, "fetch_stall");
      add(0, OP_BR, 1, 1, F_GO, "br_fetch");
      add(0, OP_BR, 1, 1, DEC,  "br_dec_no_pcw");
      add(0, OP_BR, 1, 1, BR_T, "br_taken");
      add(0, OP_BR, 0, 1, F_GO, "br2_fetch");
      add(0, OP_BR, 0, 1, DEC,  "br2_dec");
      add(0, OP_BR, 0, 1, BR_N, "br_not_taken");
      add(0, OP_SW, 1, 1, F_GO, "sw_fetch");
      add(0, OP_SW, 0, 1, DEC,  "sw_dec");
      add(0, OP_SW, 0, 1, MAD,  "sw_adr");
      add(0, OP_SW, 0, 0, MWR,  "sw_wait");
      add(0, OP_SW, 0, 1, MWR,  "sw_done");
      add(0, OP_JAL, 0, 1, F_GO, "jal_fetch");
      add(0, OP_JAL, 0, 1, DEC,  "jal_dec");
      add(0, OP_JAL, 0, 1, JAL,  "jal");
      add(0, OP_JAL, 0, 1, AWB,  "jal_wb");
      add(0, OP_LUI, 0, 1, F_GO, "lui_fetch");
      add(0, OP_LUI, 0, 1, DEC,  "lui_dec");
      add(0, OP_LUI, 0, 1, LUI,  "lui");
      add(0, OP_LUI, 0, 1, AWB,  "lui_wb");
      add(0, OP_I, 0, 1, F_GO, "imm_fetch");
      add(0, OP_I, 0, 1, DEC,  "imm_dec");
      add(0, OP_I, 0, 1, EXI,  "imm_exec");
      add(0, OP_I, 0, 1, AWB,  "imm_wb");
      add(0, OP_BAD, 0, 1, F_GO, "bad_fetch");
      add(0, OP_BAD, 0, 1, DEC,  "bad_dec");
      add(0, OP_BAD, 0, 1, ILL,  "illegal1");
      add(0, OP_BAD, 0, 1, ILL,  "illegal_hold");
      add(0, OP_R,   0, 1, ILL,  "illegal_ignores_op");
      add(1, OP_R,   0, 1, ILL,  "illegal_in_reset");
      add(0, OP_LW, 0, 1, F_GO, "post_ill_fetch");
      add(0, OP_LW, 0, 1, DEC,  "lw3_dec");
      add(0, OP_LW, 0, 1, MAD,  "lw3_adr");
      add(0, OP_LW, 0, 0, MRD,  "lw3_stall");
      add(1, OP_LW, 0, 0, R_MRD, "reset_mid_stall");
      add(0, OP_LW, 0, 1, F_GO, "fetch_after_abort");

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].opc, vq[i].bc, vq[i].rdy);
         check(vq[i].name, act, vq[i].exp);
      end

      // illegal trap: halting instance parks, non-halting one pulses and refetches
      drive(1, OP_BAD, 0, 1);
      drive(0, OP_BAD, 0, 1);
      check("nh_fetch", act2, F_GO);
      drive(0, OP_BAD, 0, 1);
      check("nh_dec", act2, DEC);
      drive(0, OP_BAD, 0, 1);
      check("nh_illegal_pulse", act2, ILL);
      check("h_illegal", act, ILL);
      drive(0, OP_R, 0, 1);
      check("nh_back_to_fetch", act2, F_GO);
      check("h_still_illegal", act, ILL);
      drive(0, OP_R, 0, 1);
      check("nh_refetch_dec", act2, DEC);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
